game_ctrl: RTL
==============

Name: game_ctrl

Overview:
- Top-level game-state and collision controller for the dinosaur runner.
- Sits directly upstream of the dinosaur jump/sprite stage and drives its game_status input.
- Consumes the dinosaur sprite pixel and the obstacle pixel for each display cycle, and detects overlap per frame.
- Runs the IDLE/RUN/OVER state machine and maintains BCD current and high scores for the score display stage.

Parameters:
- HIT_THRESH, 4: number of overlapping pixels within one frame that counts as a collision (tolerates edge noise).
- SCORE_DIV, 6: frame ticks per score increment while running.
- HIT_CNT_W, 12: width of the per-frame overlap counter.

Ports:
- CLK  in  1  pixel/system clock; all logic is on posedge CLK.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  start/restart request, level, synchronous to CLK.
- fresh  in  1  frame strobe from the VGA timing stage; a falling edge marks the frame boundary.
- dino_px  in  1  dinosaur sprite pixel for the current row_addr/col_addr.
- obstacle_px  in  1  obstacle pixel for the same position, aligned with dino_px.
- game_status  out  1  1 while the game is running; 0 when idle or over.
- game_over  out  1  1 in the OVER state.
- score  out  16  current score, 4 BCD digits, [15:12] most significant.
- hi_score  out  16  best score since RESET, 4 BCD digits.
- frame_tick  out  1  one-cycle pulse on each detected falling edge of fresh.

Behaviour:
- Reset (asynchronous):
  - state=IDLE; game_status=0; game_over=0.
  - score=0; hi_score=0; frame_tick=0.
  - hit_cnt=0; div_cnt=0; fresh_q=1.
- Frame edge detection:
  - fresh_q is fresh registered.
  - frame_tick is asserted for exactly one cycle when fresh_q=1 and fresh=0 (registered, so it appears one cycle after the edge is sampled).
- States:
  - IDLE: START=1 -> RUN; score, hit_cnt and div_cnt are cleared.
  - RUN: on a frame_tick cycle, if hit_cnt >= HIT_THRESH -> OVER; otherwise stay in RUN. START is ignored in RUN.
  - OVER: START=1 -> RUN; score, hit_cnt and div_cnt are cleared. hi_score is retained.
- game_status=1 only in RUN. game_over=1 only in OVER. Both outputs are registered.
- Overlap counting:
  - In RUN, on cycles that are not frame_tick cycles, dino_px & obstacle_px increments hit_cnt.
  - hit_cnt saturates at 2^HIT_CNT_W-1.
  - On a frame_tick cycle, hit_cnt is compared and then cleared to 0. A pixel coincident with the tick is discarded.
- Scoring:
  - On each frame_tick in RUN that does not cause the transition to OVER, div_cnt increments.
  - When div_cnt reaches SCORE_DIV-1 it wraps to 0 and score increments by 1 in BCD; each digit carries 9->0.
  - score saturates at 9999 and does not wrap.
- High score: on the RUN->OVER transition, if score > hi_score (BCD compare, equivalent to binary compare on valid BCD), hi_score <= score in the same cycle.
- Simultaneous events:
  - START and frame_tick in the same cycle in OVER: go to RUN with counters cleared; no collision check that cycle.
  - Collision and score increment due on the same tick: the collision wins, and score is not incremented.
- RESET asserted mid-game returns immediately to IDLE and clears hi_score.

Decomposition:
- Shared package game_pkg:
  - state enum {IDLE, RUN, OVER}.
  - BCD_DIGITS=4.
  - BCD_W=16.
  - BCD_MAX=16'h9999.
- One sub-module, bcd_counter4: inputs clk, rst, clr, inc; output 16-bit BCD value. Provides ripple carry per digit and saturation at 9999.

Test Plan:
- Reset then START=1 for one cycle -> game_status=1 on the next cycle; score=16'h0000; game_over=0.
- RUN with no overlap, 12 falling edges of fresh -> score=16'h0002; exactly 12 single-cycle frame_tick pulses.
- In RUN, 3 overlapping pixels in one frame then a tick -> remains in RUN. 4 overlapping pixels in the next frame then a tick -> game_over=1, game_status=0, hi_score equals score.
- Preload so that score=16'h0099, then SCORE_DIV ticks -> 16'h0100. Force 16'h9999, then further increments -> stays 16'h9999.
- In OVER, START coincident with a frame tick -> RUN; score=0; hi_score unchanged. A second game ending with a lower score leaves hi_score unchanged.
- Assert RESET asynchronously mid-RUN (not on a clock edge) -> all outputs zero immediately, state=IDLE, hi_score=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the dinosaur runner game controller.
package game_pkg;
  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 16;
  localparam logic [BCD_W-1:0] BCD_MAX = 16'h9999;
endpackage

// File: rtl/game_ctrl_if.sv
// Control/status bundle between the game controller and its neighbours.
interface game_ctrl_if import game_pkg::*; ();
  logic             START;
  logic             fresh;
  logic             dino_px;
  logic             obstacle_px;
  logic             game_status;
  logic             game_over;
  logic [BCD_W-1:0] score;
  logic [BCD_W-1:0] hi_score;
  logic             frame_tick;

  modport master (
    output START, fresh, dino_px, obstacle_px,
    input  game_status, game_over, score, hi_score, frame_tick
  );
  modport slave (
    input  START, fresh, dino_px, obstacle_px,
    output game_status, game_over, score, hi_score, frame_tick
  );
endinterface

// File: rtl/game_ctrl_bcd_counter4.sv
// Four-digit BCD up-counter with per-digit ripple carry, holding at 9999.
module bcd_counter4
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] value
);
  logic [BCD_DIGITS-1:0] carry;
  logic                  sat;

  assign sat      = (value == BCD_MAX);
  assign carry[0] = inc & ~sat;

  for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_dig
    logic [3:0] dig_q;
    assign value[4*d +: 4] = dig_q;

    if (d < BCD_DIGITS-1) begin : g_cy
      assign carry[d+1] = carry[d] & (dig_q == 4'd9);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)           dig_q <= '0;
      else if (clr)      dig_q <= '0;
      else if (carry[d]) dig_q <= (dig_q == 4'd9) ? 4'd0 : dig_q + 4'd1;
    end
  end
endmodule

// File: rtl/game_ctrl.sv
// Game state machine, per-frame dino/obstacle overlap detection and BCD scoring.
module game_ctrl
  import game_pkg::*;
#(
  parameter int HIT_THRESH = 4,
  parameter int SCORE_DIV  = 6,
  parameter int HIT_CNT_W  = 12
) (
  input  logic      CLK,
  input  logic      RESET,
  game_ctrl_if.slave bus
);
  localparam int DIV_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;

  state_t               state, state_nxt;
  logic                 fresh_q, frame_tick;
  logic [HIT_CNT_W-1:0] hit_cnt;
  logic [DIV_W-1:0]     div_cnt;
  logic [BCD_W-1:0]     score, hi_score;
  logic                 game_status, game_over;
  logic                 clr, adv, load_hi, collide, div_wrap, hit;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fresh_q    <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      fresh_q    <= bus.fresh;
      frame_tick <= fresh_q & ~bus.fresh;
    end
  end

  assign collide  = (hit_cnt >= HIT_CNT_W'(HIT_THRESH));
  assign div_wrap = (div_cnt == DIV_W'(SCORE_DIV-1));
  assign hit      = bus.dino_px & bus.obstacle_px;

  // A collision tick takes priority over the score advance on that tick.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    adv       = 1'b0;
    load_hi   = 1'b0;
    case (state)
      IDLE, OVER: begin
        if (bus.START) begin
          state_nxt = RUN;
          clr       = 1'b1;
        end
      end
      RUN: begin
        if (frame_tick) begin
          if (collide) begin
            state_nxt = OVER;
            load_hi   = (score > hi_score);
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      game_status <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_nxt;
      game_status <= (state_nxt == RUN);
      game_over   <= (state_nxt == OVER);
    end
  end

  // The pixel pair arriving on the tick cycle belongs to neither frame.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                   hit_cnt <= '0;
    else if (clr || frame_tick)  hit_cnt <= '0;
    else if (state == RUN && hit && !(&hit_cnt))
                                 hit_cnt <= hit_cnt + 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)    div_cnt <= '0;
    else if (clr) div_cnt <= '0;
    else if (adv) div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)        hi_score <= '0;
    else if (load_hi) hi_score <= score;
  end

  bcd_counter4 u_score (
    .clk   (CLK),
    .rst   (RESET),
    .clr   (clr),
    .inc   (adv & div_wrap),
    .value (score)
  );

  assign bus.game_status = game_status;
  assign bus.game_over   = game_over;
  assign bus.score       = score;
  assign bus.hi_score    = hi_score;
  assign bus.frame_tick  = frame_tick;
endmodule
